// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-slave transaction controller.
// Holds the state encoding, default frame geometry, R/W bit polarity and
// the Moore strobe decode used by the controller.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 8;
  localparam int unsigned SPI_CNT_W      = 4;

  // Value of the R/W bit (parallel-out bit 0 after the address frame) that selects a read.
  localparam logic RW_READ = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_GET_ADDR     = 4'd1,
    ST_ADDR_SETTLE  = 4'd2,
    ST_DECODE       = 4'd3,
    ST_READ_LOAD    = 4'd4,
    ST_READ_SHIFT   = 4'd5,
    ST_WRITE_GET    = 4'd6,
    ST_WRITE_SETTLE = 4'd7,
    ST_WRITE_COMMIT = 4'd8,
    ST_DONE         = 4'd9
  } state_e;

  // Moore strobes; everything except the shift enable is a pure function of state.
  typedef struct packed {
    logic sr_load;
    logic addr_we;
    logic dm_we;
    logic miso_oe;
    logic busy;
  } strobe_t;

  function automatic strobe_t decode_strobes(input state_e s);
    strobe_t st;
    st      = '0;
    st.busy = (s != ST_IDLE);
    case (s)
      ST_DECODE:       st.addr_we = 1'b1;
      ST_READ_LOAD:    st.sr_load = 1'b1;
      ST_READ_SHIFT:   st.miso_oe = 1'b1;
      ST_WRITE_COMMIT: st.dm_we   = 1'b1;
      default:         ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/spi_transaction_fsm_if.sv
// Bus between the transaction controller and its neighbours.
//   cs_n, sclk_pos_edge, sclk_neg_edge : conditioned chip select / SCLK edge pulses
//   sr_lsb                             : shift-register parallel-out bit 0
//   sr_shift_en, sr_load               : shift-register strobes
//   addr_we, dm_we, miso_oe, busy      : address latch, memory, MISO buffer, status
// master: the controller. slave: the surrounding datapath / conditioners.
interface spi_transaction_fsm_if;

  logic cs_n;
  logic sclk_pos_edge;
  logic sclk_neg_edge;
  logic sr_lsb;

  logic sr_shift_en;
  logic sr_load;
  logic addr_we;
  logic dm_we;
  logic miso_oe;
  logic busy;

  modport master (
    input  cs_n, sclk_pos_edge, sclk_neg_edge, sr_lsb,
    output sr_shift_en, sr_load, addr_we, dm_we, miso_oe, busy
  );

  modport slave (
    output cs_n, sclk_pos_edge, sclk_neg_edge, sr_lsb,
    input  sr_shift_en, sr_load, addr_we, dm_we, miso_oe, busy
  );

endinterface

// File: rtl/spi_bit_counter.sv
// Frame bit counter.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the count (wins over inc)
//   inc        : count one accepted SCLK edge
//   count      : current count
//   done       : this inc completes the frame
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS = SPI_FRAME_BITS,
  parameter int unsigned CNT_W      = SPI_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = inc & (count_q == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/spi_transaction_fsm.sv
// Sequencer for one SPI-slave memory transaction: an address/RW frame
// followed by a data frame that is either shifted in (write) or out (read).
//   clk, rst_n : clock, async active-low reset
//   bus        : controller side of spi_transaction_fsm_if (edge pulses and
//                sr_lsb in; shift/load/latch/memory/MISO strobes and busy out)
// Only sequencing state lives here; data stays in the shift register.
module spi_transaction_fsm
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS = SPI_FRAME_BITS,
  parameter int unsigned CNT_W      = SPI_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_transaction_fsm_if.master bus
);

  state_e           state_q;
  state_e           state_d;
  strobe_t          strobe_q;
  logic             shift_en;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_done;
  logic             cnt_room;
  logic [CNT_W-1:0] cnt;

  spi_bit_counter #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (cnt),
    .done  (cnt_done)
  );

  // Keeps the counter from ever passing a full frame.
  assign cnt_room = (cnt < CNT_W'(FRAME_BITS));

  // Next-state, counter control and the Mealy shift enable.
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (!bus.cs_n) state_d = ST_GET_ADDR;
      end
      // Both inbound frames are sampled on SCLK rising edges.
      ST_GET_ADDR, ST_WRITE_GET: begin
        shift_en = bus.sclk_pos_edge;
        cnt_inc  = bus.sclk_pos_edge & cnt_room;
        if (cnt_done) begin
          state_d = (state_q == ST_GET_ADDR) ? ST_ADDR_SETTLE : ST_WRITE_SETTLE;
        end
      end
      ST_ADDR_SETTLE: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        cnt_clear = 1'b1;
        state_d   = (bus.sr_lsb == RW_READ) ? ST_READ_LOAD : ST_WRITE_GET;
      end
      ST_READ_LOAD: begin
        cnt_clear = 1'b1;
        state_d   = ST_READ_SHIFT;
      end
      // Read data leaves on SCLK falling edges so the master samples it on the next rise.
      ST_READ_SHIFT: begin
        shift_en = bus.sclk_neg_edge;
        cnt_inc  = bus.sclk_neg_edge & cnt_room;
        if (cnt_done) state_d = ST_DONE;
      end
      ST_WRITE_SETTLE: begin
        state_d = ST_WRITE_COMMIT;
      end
      ST_WRITE_COMMIT: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Deselect aborts from any state; nothing shifts or counts in that cycle.
    if (bus.cs_n) begin
      state_d   = ST_IDLE;
      shift_en  = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore strobes registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= decode_strobes(state_d);
    end
  end

  assign bus.sr_shift_en = shift_en;
  assign bus.sr_load     = strobe_q.sr_load;
  assign bus.addr_we     = strobe_q.addr_we;
  assign bus.dm_we       = strobe_q.dm_we;
  assign bus.miso_oe     = strobe_q.miso_oe;
  assign bus.busy        = strobe_q.busy;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Bench for spi_transaction_fsm. Each transaction is generated as a whole
// (random SCLK edge pulses, chip-select window, R/W bit), and the expected
// per-cycle strobe timeline is derived from the cycle numbers of the 8th
// address / data edges. Outputs are compared every cycle on the falling clock.
module tb_spi_transaction_fsm;

  localparam int FB   = 8;
  localparam int MAXC = 160;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spi_transaction_fsm_if bus ();

  spi_transaction_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic       pos_a [MAXC];
  logic       neg_a [MAXC];
  logic       lsb_a [MAXC];
  logic [5:0] exp_a [MAXC];

  // {sr_shift_en, sr_load, addr_we, dm_we, miso_oe, busy}
  function automatic logic [5:0] observe();
    return {bus.sr_shift_en, bus.sr_load, bus.addr_we, bus.dm_we, bus.miso_oe, bus.busy};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Cycle index of the n-th pulse at or after start.
  function automatic int nth_pulse(input bit use_neg, input int start, input int n);
    int seen;
    seen = 0;
    for (int t = start; t < MAXC; t++) begin
      if (use_neg ? neg_a[t] : pos_a[t]) begin
        seen++;
        if (seen == n) return t;
      end
    end
    return MAXC - 8;
  endfunction

  // abort_phase: 0 none, 1 after abort_k address edges, 2 after abort_k write-data edges.
  // tail: cycles with cs_n high at the end (1 gives a one-cycle IDLE gap).
  task automatic run_txn(input string name, input logic [7:0] frame, input int abort_phase,
                         input int abort_k, input bit coincide, input int tail);
    int         a8, n8, d8, fin, cs_hi, len;
    bit         rd;
    logic [5:0] e;
    logic [5:0] obs;

    rd = frame[0];
    n8 = -1;
    d8 = -1;
    for (int t = 0; t < MAXC; t++) begin
      pos_a[t] = (t % 3 == 1) || ($urandom_range(0, 3) == 0);
      neg_a[t] = coincide ? pos_a[t] : ((t % 3 == 2) || ($urandom_range(0, 3) == 0));
      lsb_a[t] = 1'($urandom_range(0, 1));
    end

    a8 = nth_pulse(1'b0, 1, FB);
    if (rd) begin
      n8  = nth_pulse(1'b1, a8 + 4, FB);
      fin = n8 + 1;
    end else begin
      d8  = nth_pulse(1'b0, a8 + 3, FB);
      fin = d8 + 3;
    end
    lsb_a[a8 + 2] = frame[0];

    if (abort_phase == 1)      cs_hi = nth_pulse(1'b0, 1, abort_k) + 1;
    else if (abort_phase == 2) cs_hi = nth_pulse(1'b0, a8 + 3, abort_k) + 1;
    else                       cs_hi = fin + int'($urandom_range(0, 3));
    len = cs_hi + tail;

    for (int t = 0; t < len; t++) begin
      e = '0;
      if (t >= 1 && t <= cs_hi) begin
        e[0] = 1'b1;
        if (t <= a8)            e[5] = pos_a[t];
        else if (t == a8 + 2)   e[3] = 1'b1;
        else if (rd) begin
          if (t == a8 + 3)                    e[4] = 1'b1;
          else if (t >= a8 + 4 && t <= n8) begin
            e[1] = 1'b1;
            e[5] = neg_a[t];
          end
        end else begin
          if (t >= a8 + 3 && t <= d8) e[5] = pos_a[t];
          else if (t == d8 + 2)       e[2] = 1'b1;
        end
        if (t == cs_hi) e[5] = 1'b0;
      end
      exp_a[t] = e;
    end

    for (int t = 0; t < len; t++) begin
      bus.cs_n          = (t >= cs_hi);
      bus.sclk_pos_edge = pos_a[t];
      bus.sclk_neg_edge = neg_a[t];
      bus.sr_lsb        = lsb_a[t];
      @(negedge clk);
      obs = observe();
      check($sformatf("%s c%0d", name, t), obs, exp_a[t]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int         ph;
    logic [7:0] fr;

    // Reset state, asynchronously before any clock edge.
    rst_n             = 1'b0;
    bus.cs_n          = 1'b1;
    bus.sclk_pos_edge = 1'b0;
    bus.sclk_neg_edge = 1'b0;
    bus.sr_lsb        = 1'b0;
    #2;
    check("reset_async", observe(), 6'b000000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Deselected after reset: stays idle.
    repeat (2) begin
      @(negedge clk);
      check("idle_after_reset", observe(), 6'b000000);
      @(posedge clk);
      #1;
    end

    // Enter address phase and take 5 edges, then reset mid-cycle.
    bus.cs_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      bus.sclk_pos_edge = 1'b1;
      @(posedge clk);
      #1;
      bus.sclk_pos_edge = 1'b0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("mid_addr_busy", observe(), 6'b000001);
    bus.sclk_pos_edge = 1'b1;
    #1;
    check("mid_addr_shift", observe(), 6'b100001);
    rst_n    = 1'b0;
    bus.cs_n = 1'b1;
    #1;
    check("reset_mid_addr", observe(), 6'b000000);
    @(posedge clk);
    #1;
    bus.sclk_pos_edge = 1'b0;
    rst_n             = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_after_rst2", observe(), 6'b000000);
      @(posedge clk);
      #1;
    end

    // Directed transactions.
    run_txn("wr54",      8'h54, 0, 0, 1'b0, 3);
    run_txn("rd55",      8'h55, 0, 0, 1'b0, 2);
    run_txn("wr_abort5", 8'h54, 2, 5, 1'b0, 2);
    run_txn("wr_after",  8'h54, 0, 0, 1'b0, 1);
    run_txn("wr_b2b",    8'hA6, 0, 0, 1'b0, 2);
    run_txn("wr_both",   8'h54, 0, 0, 1'b1, 2);
    run_txn("rd_both",   8'h55, 0, 0, 1'b1, 2);
    run_txn("ad_abort3", 8'h55, 1, 3, 1'b0, 2);

    // Random transactions.
    for (int i = 0; i < 10; i++) begin
      fr = 8'($urandom_range(0, 255));
      ph = int'($urandom_range(0, 2));
      if (ph == 2 && fr[0]) ph = 0;
      run_txn($sformatf("rnd%0d", i), fr, ph, int'($urandom_range(1, FB - 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_transaction_fsm.md
Name: spi_transaction_fsm

Overview:
- Controller that sequences the serial/parallel shift register for one SPI-slave memory transaction: an 8-bit address/RW frame, then an 8-bit data frame.
- Sits between the input conditioners (synchronised CS and SCLK edge pulses), the shift register, the address latch, the data memory and the MISO tri-state buffer.
- Produces every strobe those blocks need; holds no data itself, only sequencing state.

Parameters:
- FRAME_BITS, 8, bits per frame (address/RW frame and data frame); minimum 2.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > FRAME_BITS.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  conditioned chip select, active-low.
- sclk_pos_edge  input  1  one-cycle pulse per SCLK rising edge.
- sclk_neg_edge  input  1  one-cycle pulse per SCLK falling edge.
- sr_lsb  input  1  shift-register parallel-out bit 0 (the R/W bit after the address frame).
- sr_shift_en  output  1  drives the shift register's peripheralClkEdge.
- sr_load  output  1  drives the shift register's parallelLoad.
- addr_we  output  1  address-latch write enable (latches parallel-out bits [FRAME_BITS-1:1]).
- dm_we  output  1  data-memory write enable.
- miso_oe  output  1  MISO buffer enable.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bit counter=0; all outputs 0 immediately, independent of clk.
- States: IDLE, GET_ADDR, ADDR_SETTLE, DECODE, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_SETTLE, WRITE_COMMIT, DONE.
- IDLE: cs_n=0 -> GET_ADDR and clear counter.
- GET_ADDR:
  - sr_shift_en = sclk_pos_edge (combinational, same cycle).
  - Each pos edge increments the counter.
  - The pos edge that brings the counter to FRAME_BITS -> ADDR_SETTLE.
- ADDR_SETTLE: 1-cycle wait that absorbs the shift register's registered parallel output; -> DECODE.
- DECODE:
  - addr_we=1 for this cycle only; sample sr_lsb and clear the counter.
  - sr_lsb=1 -> READ_LOAD; sr_lsb=0 -> WRITE_GET.
- READ_LOAD: sr_load=1 for one cycle; -> READ_SHIFT.
- READ_SHIFT:
  - miso_oe=1; sr_shift_en = sclk_neg_edge; each neg edge increments the counter.
  - The neg edge that brings the counter to FRAME_BITS -> DONE.
- WRITE_GET: as GET_ADDR (pos edges shift, count to FRAME_BITS) -> WRITE_SETTLE.
- WRITE_SETTLE: 1-cycle wait -> WRITE_COMMIT.
- WRITE_COMMIT: dm_we=1 for one cycle; -> DONE.
- DONE: all strobes 0; remain until cs_n=1 -> IDLE. Additional SCLK edges are ignored.
- Abort:
  - cs_n=1 in any state -> IDLE on the next clk; takes priority over all other transitions.
  - No addr_we/dm_we/sr_load in the abort cycle; counter cleared.
- Edge-pulse rules:
  - sclk_pos_edge in READ_SHIFT and sclk_neg_edge in GET_ADDR/WRITE_GET are ignored.
  - Both pulses high in the same cycle: only the one relevant to the current state counts.
- Counter: CNT_W bits, never exceeds FRAME_BITS, cleared on entry to GET_ADDR/READ_SHIFT/WRITE_GET and on abort.
- Outputs: addr_we, dm_we, sr_load, miso_oe and busy are Moore (state decode only); sr_shift_en is the only Mealy output.
- Latency: addr_we fires 2 clk after the 8th address pos edge; dm_we fires 2 clk after the 8th data pos edge.

Decomposition:
- Shared package spi_pkg:
  - state encoding localparams (4-bit binary);
  - FRAME_BITS/CNT_W defaults;
  - R/W bit polarity constant (RW_READ=1).
- One sub-module, spi_bit_counter:
  - ports: clk, rst_n, clear, inc, count, done;
  - done = (count == FRAME_BITS-1) & inc.

Test Plan:
- Reset: assert rst_n=0 mid-GET_ADDR with counter=5 -> all outputs 0 and busy=0 asynchronously; after release, cs_n=1 keeps IDLE.
- Write transaction: cs_n=0, shift address frame 0x54 (addr 0x2A, RW=0) then data 0xC3 on 16 pos edges -> exactly one addr_we pulse 2 clk after edge 8; exactly one dm_we pulse 2 clk after edge 16; miso_oe never high.
- Read transaction: address frame 0x55 -> addr_we, then sr_load one cycle later; miso_oe=1 for 8 neg edges; sr_shift_en pulses only on neg edges; DONE after the 8th neg edge.
- Abort: raise cs_n after 5 data pos edges of a write -> IDLE next clk, dm_we never asserted; a subsequent full write proceeds normally.
- Edge filtering: assert sclk_pos_edge and sclk_neg_edge together during GET_ADDR, and extra pos edges in DONE -> the counter counts only pos edges in GET_ADDR; no shifts or strobes in DONE.
- Back-to-back: cs_n high for 1 clk between two writes -> both commit; busy drops for exactly 1 cycle.
